// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY receive packet engine: FSM states, link constants
// and the byte-wise reflected CRC-16 step.
package dphy_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned TMO_W  = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LP_RQST,
      ST_HS_WAIT,
      ST_HDR0,
      ST_HDR1,
      ST_PAYLOAD,
      ST_CRC_HI,
      ST_CRC_FULL,
      ST_EOT
   } rx_state_e;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hB8;
   localparam logic [5:0]        DT_SHORT_MAX  = 6'h0F;
   localparam logic [WORD_W-1:0] CRC_INIT      = 16'hFFFF;
   localparam logic [WORD_W-1:0] CRC_POLY_R    = 16'h8408;

   localparam logic [1:0] LP_11 = 2'b11;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_00 = 2'b00;

   // One byte of CCITT CRC, LSB first, reflected polynomial.
   function automatic logic [WORD_W-1:0] crc16_byte(input logic [WORD_W-1:0] crc_in,
                                                   input logic [BYTE_W-1:0] data_in);
      logic [WORD_W-1:0] c;
      c = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dphy_crc16.sv
// Registered CRC-16 accumulator consuming up to two bytes per cycle (data[7:0] first).
module dphy_crc16
   import dphy_pkg::*;
(
   input  logic              i_clk,
   input  logic              reset,
   input  logic              init,
   input  logic [1:0]        en,
   input  logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] crc
);

   logic [WORD_W-1:0] crc_b0_c;
   logic [WORD_W-1:0] crc_n_c;

   always_comb begin
      crc_b0_c = en[0] ? crc16_byte(crc, data[7:0]) : crc;
      crc_n_c  = en[1] ? crc16_byte(crc_b0_c, data[15:8]) : crc_b0_c;
   end

   always_ff @(posedge i_clk) begin
      if (reset) begin
         crc <= '0;
      end else if (init) begin
         crc <= CRC_INIT;
      end else begin
         crc <= crc_n_c;
      end
   end

endmodule

// File: rtl/dphy_rx_packet_rx.sv
// D-PHY 2-lane receive packet engine: LP request detect, SoT lock, header decode,
// payload streaming with CRC-16 check and packet status pulses.
module dphy_rx_packet_rx
   import dphy_pkg::*;
#(
   parameter int unsigned       SYNC_TIMEOUT = 255,
   parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] byte_D0,
   input  logic [BYTE_W-1:0] byte_D1,
   input  logic [1:0]        lp0_in,
   output logic              hdr_valid,
   output logic [BYTE_W-1:0] hdr_di,
   output logic [WORD_W-1:0] hdr_wc,
   output logic [BYTE_W-1:0] hdr_ecc,
   output logic              pl_valid,
   output logic [WORD_W-1:0] pl_data,
   output logic [1:0]        pl_be,
   output logic              pkt_done,
   output logic              crc_ok,
   output logic              pkt_err
);

   rx_state_e         state, state_n;
   logic [1:0]        lp_prev;
   logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
   logic [WORD_W-1:0] rem, rem_n;
   logic [BYTE_W-1:0] crc_lo_q, crc_lo_n;

   logic              hdr_valid_n, pl_valid_n, pkt_done_n, crc_ok_n, pkt_err_n;
   logic [BYTE_W-1:0] hdr_di_n, hdr_ecc_n;
   logic [WORD_W-1:0] hdr_wc_n, pl_data_n;
   logic [1:0]        pl_be_n;

   logic              crc_init_c;
   logic [1:0]        crc_en_c;
   logic [WORD_W-1:0] crc_val;
   logic              abort_c;
   logic [WORD_W-1:0] wc_full_c;

   dphy_crc16 u_crc (
      .i_clk (i_clk),
      .reset (reset),
      .init  (crc_init_c),
      .en    (crc_en_c),
      .data  ({byte_D1, byte_D0}),
      .crc   (crc_val)
   );

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         lp_prev   <= LP_00;
         tmo_cnt   <= '0;
         rem       <= '0;
         crc_lo_q  <= '0;
         hdr_valid <= 1'b0;
         hdr_di    <= '0;
         hdr_wc    <= '0;
         hdr_ecc   <= '0;
         pl_valid  <= 1'b0;
         pl_data   <= '0;
         pl_be     <= '0;
         pkt_done  <= 1'b0;
         crc_ok    <= 1'b0;
         pkt_err   <= 1'b0;
      end else begin
         state     <= state_n;
         lp_prev   <= lp0_in;
         tmo_cnt   <= tmo_cnt_n;
         rem       <= rem_n;
         crc_lo_q  <= crc_lo_n;
         hdr_valid <= hdr_valid_n;
         hdr_di    <= hdr_di_n;
         hdr_wc    <= hdr_wc_n;
         hdr_ecc   <= hdr_ecc_n;
         pl_valid  <= pl_valid_n;
         pl_data   <= pl_data_n;
         pl_be     <= pl_be_n;
         pkt_done  <= pkt_done_n;
         crc_ok    <= crc_ok_n;
         pkt_err   <= pkt_err_n;
      end
   end

   // LP-11 during any HS packet phase aborts and overrides the data path.
   assign abort_c = (lp0_in == LP_11) &&
                    ((state == ST_HDR0) || (state == ST_HDR1) || (state == ST_PAYLOAD) ||
                     (state == ST_CRC_HI) || (state == ST_CRC_FULL));

   assign wc_full_c = {byte_D0, hdr_wc[7:0]};

   always_comb begin
      state_n     = state;
      tmo_cnt_n   = tmo_cnt;
      rem_n       = rem;
      crc_lo_n    = crc_lo_q;
      hdr_valid_n = 1'b0;
      hdr_di_n    = hdr_di;
      hdr_wc_n    = hdr_wc;
      hdr_ecc_n   = hdr_ecc;
      pl_valid_n  = 1'b0;
      pl_data_n   = pl_data;
      pl_be_n     = pl_be;
      pkt_done_n  = 1'b0;
      crc_ok_n    = 1'b0;
      pkt_err_n   = 1'b0;
      crc_init_c  = 1'b0;
      crc_en_c    = 2'b00;

      if (abort_c) begin
         pkt_err_n = 1'b1;
         state_n   = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((lp_prev == LP_11) && (lp0_in == LP_01)) begin
                  state_n = ST_LP_RQST;
               end
            end
            ST_LP_RQST: begin
               if (lp0_in == LP_00) begin
                  state_n   = ST_HS_WAIT;
                  tmo_cnt_n = '0;
               end else if (lp0_in != LP_01) begin
                  state_n = ST_IDLE;
               end
            end
            ST_HS_WAIT: begin
               if ((byte_D0 == SYNC_BYTE) && (byte_D1 == SYNC_BYTE)) begin
                  state_n   = ST_HDR0;
                  tmo_cnt_n = '0;
               end else if ((32'(tmo_cnt) + 32'd1) >= SYNC_TIMEOUT) begin
                  pkt_err_n = 1'b1;
                  state_n   = ST_IDLE;
                  tmo_cnt_n = '0;
               end else begin
                  tmo_cnt_n = tmo_cnt + 16'd1;
               end
            end
            ST_HDR0: begin
               hdr_di_n = byte_D0;
               hdr_wc_n = {hdr_wc[15:8], byte_D1};
               state_n  = ST_HDR1;
            end
            ST_HDR1: begin
               hdr_wc_n    = wc_full_c;
               hdr_ecc_n   = byte_D1;
               hdr_valid_n = 1'b1;
               if (hdr_di[5:0] <= DT_SHORT_MAX) begin
                  pkt_done_n = 1'b1;
                  crc_ok_n   = 1'b1;
                  state_n    = ST_EOT;
               end else begin
                  crc_init_c = 1'b1;
                  rem_n      = wc_full_c;
                  state_n    = (wc_full_c == '0) ? ST_CRC_FULL : ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               pl_valid_n = 1'b1;
               if (rem == 16'd1) begin
                  // Odd tail: lane 1 already carries the low CRC byte.
                  pl_data_n = {8'h00, byte_D0};
                  pl_be_n   = 2'b01;
                  crc_en_c  = 2'b01;
                  crc_lo_n  = byte_D1;
                  rem_n     = '0;
                  state_n   = ST_CRC_HI;
               end else begin
                  pl_data_n = {byte_D1, byte_D0};
                  pl_be_n   = 2'b11;
                  crc_en_c  = 2'b11;
                  rem_n     = rem - 16'd2;
                  if (rem == 16'd2) begin
                     state_n = ST_CRC_FULL;
                  end
               end
            end
            ST_CRC_FULL: begin
               pkt_done_n = 1'b1;
               crc_ok_n   = ({byte_D1, byte_D0} == crc_val);
               state_n    = ST_EOT;
            end
            ST_CRC_HI: begin
               pkt_done_n = 1'b1;
               crc_ok_n   = ({byte_D0, crc_lo_q} == crc_val);
               state_n    = ST_EOT;
            end
            ST_EOT: begin
               if (lp0_in == LP_11) begin
                  state_n = ST_IDLE;
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dphy_rx_packet_rx.sv
// Directed self-checking bench for the D-PHY receive packet engine.
module tb_dphy_rx_packet_rx;

   logic        i_clk = 1'b0;
   logic        reset;
   logic [7:0]  byte_D0, byte_D1;
   logic [1:0]  lp0_in;
   logic        hdr_valid;
   logic [7:0]  hdr_di;
   logic [15:0] hdr_wc;
   logic [7:0]  hdr_ecc;
   logic        pl_valid;
   logic [15:0] pl_data;
   logic [1:0]  pl_be;
   logic        pkt_done;
   logic        crc_ok;
   logic        pkt_err;

   int checks   = 0;
   int failures = 0;

   logic [17:0] pl_q[$];
   int          n_done;
   int          n_err;

   always #5 i_clk = ~i_clk;

   dphy_rx_packet_rx #(
      .SYNC_TIMEOUT (8),
      .SYNC_BYTE    (8'hB8)
   ) dut (
      .i_clk     (i_clk),
      .reset     (reset),
      .byte_D0   (byte_D0),
      .byte_D1   (byte_D1),
      .lp0_in    (lp0_in),
      .hdr_valid (hdr_valid),
      .hdr_di    (hdr_di),
      .hdr_wc    (hdr_wc),
      .hdr_ecc   (hdr_ecc),
      .pl_valid  (pl_valid),
      .pl_data   (pl_data),
      .pl_be     (pl_be),
      .pkt_done  (pkt_done),
      .crc_ok    (crc_ok),
      .pkt_err   (pkt_err)
   );

   // Event recorder, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (pl_valid) pl_q.push_back({pl_be, pl_data});
      if (pkt_done) n_done++;
      if (pkt_err)  n_err++;
   end

   // Bit-serial reference CRC used to build the transmitted CRC bytes.
   function automatic logic [15:0] ref_crc(input logic [7:0] p[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (p[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ p[i][b];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   task automatic drive(input logic [1:0] lp, input logic [7:0] d0, input logic [7:0] d1);
      lp0_in  = lp;
      byte_D0 = d0;
      byte_D1 = d1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_mon();
      pl_q.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   task automatic send_sot();
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b01, 8'h00, 8'h00);
      drive(2'b00, 8'h00, 8'h00);
      drive(2'b00, 8'hB8, 8'hB8);
   endtask

   task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
      drive(2'b00, di, wc[7:0]);
      drive(2'b00, wc[15:8], ecc);
   endtask

   // Payload followed by CRC low/high, packed two bytes per cycle.
   task automatic send_body(input logic [7:0] p[$], input logic flip);
      logic [7:0]  s[$];
      logic [15:0] c;
      c = ref_crc(p);
      if (flip) c = c ^ 16'h0100;
      s = p;
      s.push_back(c[7:0]);
      s.push_back(c[15:8]);
      if (s.size() % 2 != 0) s.push_back(8'h00);
      for (int i = 0; i < s.size(); i += 2) drive(2'b00, s[i], s[i+1]);
   endtask

   task automatic finish_eot();
      drive(2'b00, 8'h5A, 8'hA5);
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00);
      checks++;
      if ({hdr_valid, hdr_di, hdr_wc, hdr_ecc, pl_valid, pl_data, pl_be, pkt_done, crc_ok, pkt_err} !== 55'd0) begin
         failures++;
         $display("FAIL reset_outputs: got hv=%b di=%h wc=%h ecc=%h plv=%b pld=%h be=%b done=%b ok=%b err=%b, need all 0",
                  hdr_valid, hdr_di, hdr_wc, hdr_ecc, pl_valid, pl_data, pl_be, pkt_done, crc_ok, pkt_err);
      end
      reset = 1'b0;
      drive(2'b11, 8'h00, 8'h00);
   endtask

   task automatic test_short();
      clear_mon();
      send_sot();
      send_hdr(8'h00, 16'h0000, 8'h07);
      checks++;
      if (hdr_valid !== 1'b1) begin failures++; $display("FAIL short_hdr_valid: got %b need 1", hdr_valid); end
      checks++;
      if ({hdr_di, hdr_wc, hdr_ecc} !== 32'h00_0000_07) begin
         failures++; $display("FAIL short_hdr_fields: got %h/%h/%h need 00/0000/07", hdr_di, hdr_wc, hdr_ecc);
      end
      checks++;
      if ({pkt_done, crc_ok} !== 2'b11) begin
         failures++; $display("FAIL short_done: got done=%b ok=%b need 1 1", pkt_done, crc_ok);
      end
      finish_eot();
      checks++;
      if (pl_q.size() != 0 || n_done != 1) begin
         failures++; $display("FAIL short_no_payload: got words=%0d done=%0d need 0 1", pl_q.size(), n_done);
      end
   endtask

   task automatic test_long_even();
      logic [7:0] p[$];
      clear_mon();
      p = {8'h01, 8'h02, 8'h03, 8'h04};
      send_sot();
      send_hdr(8'h2A, 16'd4, 8'h11);
      checks++;
      if (hdr_valid !== 1'b1 || hdr_di !== 8'h2A || hdr_wc !== 16'd4) begin
         failures++; $display("FAIL even_hdr: got hv=%b di=%h wc=%h need 1 2A 0004", hdr_valid, hdr_di, hdr_wc);
      end
      send_body(p, 1'b0);
      checks++;
      if ({pkt_done, crc_ok} !== 2'b11) begin
         failures++; $display("FAIL even_crc: got done=%b ok=%b need 1 1", pkt_done, crc_ok);
      end
      finish_eot();
      checks++;
      if (pl_q.size() != 2) begin
         failures++; $display("FAIL even_count: got %0d words need 2", pl_q.size());
      end else if (pl_q[0] !== {2'b11, 16'h0201} || pl_q[1] !== {2'b11, 16'h0403}) begin
         failures++; $display("FAIL even_words: got %h %h need 30201 30403", pl_q[0], pl_q[1]);
      end
   endtask

   task automatic test_long_odd(input logic flip);
      logic [7:0] p[$];
      clear_mon();
      p = {8'hAA, 8'hBB, 8'hCC};
      send_sot();
      send_hdr(8'h2B, 16'd3, 8'h22);
      send_body(p, flip);
      checks++;
      if (pkt_done !== 1'b1 || crc_ok !== !flip) begin
         failures++; $display("FAIL odd_crc flip=%b: got done=%b ok=%b need 1 %b", flip, pkt_done, crc_ok, !flip);
      end
      finish_eot();
      checks++;
      if (pl_q.size() != 2) begin
         failures++; $display("FAIL odd_count: got %0d words need 2", pl_q.size());
      end else if (pl_q[0] !== {2'b11, 16'hBBAA} || pl_q[1] !== {2'b01, 16'h00CC}) begin
         failures++; $display("FAIL odd_words: got %h %h need 3BBAA 100CC", pl_q[0], pl_q[1]);
      end
   endtask

   task automatic test_zero_len();
      logic [7:0] p[$];
      clear_mon();
      p.delete();
      send_sot();
      send_hdr(8'h12, 16'd0, 8'h33);
      drive(2'b00, 8'hFF, 8'hFF);
      checks++;
      if ({pkt_done, crc_ok} !== 2'b11) begin
         failures++; $display("FAIL zero_crc: got done=%b ok=%b need 1 1", pkt_done, crc_ok);
      end
      finish_eot();
      checks++;
      if (pl_q.size() != 0) begin
         failures++; $display("FAIL zero_no_payload: got %0d words need 0", pl_q.size());
      end
   endtask

   task automatic test_abort();
      clear_mon();
      send_sot();
      send_hdr(8'h2A, 16'd6, 8'h00);
      drive(2'b00, 8'h11, 8'h22);
      drive(2'b11, 8'h33, 8'h44);
      checks++;
      if (pkt_err !== 1'b1 || pl_valid !== 1'b0) begin
         failures++; $display("FAIL abort_pulse: got err=%b plv=%b need 1 0", pkt_err, pl_valid);
      end
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00);
      checks++;
      if (n_done != 0 || n_err != 1 || pl_q.size() != 1) begin
         failures++; $display("FAIL abort_events: got done=%0d err=%0d words=%0d need 0 1 1", n_done, n_err, pl_q.size());
      end
      test_long_even();
   endtask

   task automatic test_timeout();
      int k;
      logic seen;
      clear_mon();
      drive(2'b11, 8'h00, 8'h00);
      drive(2'b01, 8'h00, 8'h00);
      drive(2'b00, 8'h00, 8'h00);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         drive(2'b00, 8'h00, 8'h00);
         k++;
         seen = pkt_err;
      end
      checks++;
      if (!seen || k != 8) begin
         failures++; $display("FAIL timeout_latency: got seen=%b after %0d cycles need 1 after 8", seen, k);
      end
      drive(2'b00, 8'hB8, 8'hB8);
      drive(2'b00, 8'h00, 8'h00);
      checks++;
      if (n_err != 1 || pkt_err !== 1'b0 || hdr_valid !== 1'b0) begin
         failures++; $display("FAIL timeout_idle: got err_count=%0d err=%b hv=%b need 1 0 0", n_err, pkt_err, hdr_valid);
      end
      send_sot();
      send_hdr(8'h01, 16'hBEEF, 8'h3C);
      checks++;
      if (hdr_valid !== 1'b1 || hdr_wc !== 16'hBEEF || pkt_done !== 1'b1) begin
         failures++; $display("FAIL timeout_recover: got hv=%b wc=%h done=%b need 1 BEEF 1", hdr_valid, hdr_wc, pkt_done);
      end
      finish_eot();
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_sot();
      drive(2'b00, 8'h2A, 8'h05);
      checks++;
      if (hdr_di !== 8'h2A) begin
         failures++; $display("FAIL mid_capture: got di=%h need 2A", hdr_di);
      end
      reset = 1'b1;
      drive(2'b00, 8'h11, 8'h22);
      checks++;
      if ({hdr_valid, hdr_di, hdr_wc, hdr_ecc, pl_valid, pl_data, pl_be, pkt_done, crc_ok, pkt_err} !== 55'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got hv=%b di=%h wc=%h ecc=%h plv=%b pld=%h be=%b done=%b ok=%b err=%b, need all 0",
                  hdr_valid, hdr_di, hdr_wc, hdr_ecc, pl_valid, pl_data, pl_be, pkt_done, crc_ok, pkt_err);
      end
      reset = 1'b0;
      drive(2'b00, 8'h00, 8'h00);
      drive(2'b00, 8'h00, 8'h00);
      checks++;
      if (n_err != 0 || n_done != 0) begin
         failures++; $display("FAIL mid_reset_silent: got err=%0d done=%0d need 0 0", n_err, n_done);
      end
      test_short();
   endtask

   initial begin
      reset   = 1'b1;
      lp0_in  = 2'b11;
      byte_D0 = 8'h00;
      byte_D1 = 8'h00;
      n_done  = 0;
      n_err   = 0;
      test_reset();
      test_short();
      test_long_even();
      test_long_odd(1'b0);
      test_long_odd(1'b1);
      test_zero_len();
      test_abort();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
